// File: rtl/aes_inv_core.sv
// rtl/aes_inv_core.sv - iterative AES-128 inverse cipher with forward key expansion into a local store
module aes_inv_core (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [127:0] key,
    input  logic [127:0] cyphertext,
    output logic [127:0] plaintext,
    output logic         done
);

    typedef enum logic [2:0] {IDLE, KEYEXP, INIT, ROUND, FINAL, DONE} state_t;

    state_t       state;
    state_t       state_next;
    logic [3:0]   rcnt;
    logic [127:0] st;
    logic [127:0] rk [0:10];
    logic [127:0] rk_next;
    logic [127:0] sub_shift;
    logic [127:0] round_out;
    logic [127:0] final_out;
    logic         accept;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254; zero maps to zero as the S-box requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] p;
        logic [7:0] r;
        p = a;
        r = 8'h01;
        for (int i = 0; i < 7; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] b;
        b = gf_inv(a);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    // Undo the affine map first, then invert in the field.
    function automatic logic [7:0] inv_sbox(input logic [7:0] a);
        logic [7:0] b;
        b = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
        return gf_inv(b);
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] n);
        case (n)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [127:0] expand_key(input logic [127:0] prev, input logic [7:0] rc);
        logic [31:0] t;
        logic [31:0] w0;
        logic [31:0] w1;
        logic [31:0] w2;
        logic [31:0] w3;
        t  = {sbox(prev[23:16]), sbox(prev[15:8]), sbox(prev[7:0]), sbox(prev[31:24])} ^ {rc, 24'h000000};
        w0 = prev[127:96] ^ t;
        w1 = prev[95:64]  ^ w0;
        w2 = prev[63:32]  ^ w1;
        w3 = prev[31:0]   ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    // Row r of column c takes its byte from column c-r, then every byte goes through the inverse S-box.
    function automatic logic [127:0] inv_sub_shift(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8*(4*c + r) -: 8] = inv_sbox(s[127 - 8*(4*((c + 4 - r) % 4) + r) -: 8]);
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0;
        logic [7:0]   a1;
        logic [7:0]   a2;
        logic [7:0]   a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127 - 32*c -: 8];
            a1 = s[119 - 32*c -: 8];
            a2 = s[111 - 32*c -: 8];
            a3 = s[103 - 32*c -: 8];
            o[127 - 32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
            o[119 - 32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
            o[111 - 32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
            o[103 - 32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
        end
        return o;
    endfunction

    assign accept    = ((state == IDLE) || (state == DONE)) && start;
    assign sub_shift = inv_sub_shift(st);
    assign round_out = inv_mix_columns(sub_shift ^ rk[rcnt]);
    assign final_out = sub_shift ^ rk[0];
    assign rk_next   = expand_key(rk[rcnt - 4'd1], rcon(rcnt));

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // FSM next-state: a new start is only honoured once the previous block is finished
    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: if (start) state_next = KEYEXP;
            KEYEXP:     if (rcnt == 4'd10) state_next = INIT;
            INIT:       state_next = ROUND;
            ROUND:      if (rcnt == 4'd1) state_next = FINAL;
            FINAL:      state_next = DONE;
            default:    state_next = IDLE;
        endcase
    end

    // Round key store, filled forward one key per cycle; contents are only read after being written
    always_ff @(posedge clk) begin
        if (accept)                rk[0]    <= key;
        else if (state == KEYEXP)  rk[rcnt] <= rk_next;
    end

    // Cipher state, round counter and result registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st        <= '0;
            rcnt      <= 4'd0;
            plaintext <= '0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        st   <= cyphertext;
                        rcnt <= 4'd1;
                        done <= 1'b0;
                    end
                end
                KEYEXP: if (rcnt != 4'd10) rcnt <= rcnt + 4'd1;
                INIT: begin
                    st   <= st ^ rk[10];
                    rcnt <= 4'd9;
                end
                ROUND: begin
                    st <= round_out;
                    if (rcnt != 4'd1) rcnt <= rcnt - 4'd1;
                end
                FINAL: begin
                    plaintext <= final_out;
                    done      <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_inv_core.sv
// tb/tb_aes_inv_core.sv - self-checking bench for aes_inv_core against a byte-level AES model
module tb_aes_inv_core;

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [127:0] key = '0;
    logic [127:0] cyphertext = '0;
    logic [127:0] plaintext;
    logic         done;

    int total = 0;
    int bad = 0;

    logic [7:0] sb_t  [0:255];
    logic [7:0] isb_t [0:255];
    logic [7:0] inv_b;
    logic [7:0] sv;
    logic [7:0] aff_c;

    logic         m_done;
    logic [127:0] m_pt;
    logic [127:0] m_next;
    logic         m_busy;
    int           m_cnt;

    int  lat;
    int  low;
    int  n;
    logic idle_ok;

    aes_inv_core dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .key        (key),
        .cyphertext (cyphertext),
        .plaintext  (plaintext),
        .done       (done)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return p;
    endfunction

    function automatic logic [127:0] model_rk(input logic [127:0] k, input int rnd);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {sb_t[t[23:16]], sb_t[t[15:8]], sb_t[t[7:0]], sb_t[t[31:24]]} ^ {rc, 24'h0};
                rc = rc[7] ? ((rc << 1) ^ 8'h1b) : (rc << 1);
            end
            w[i] = w[i-4] ^ t;
        end
        return {w[4*rnd], w[4*rnd+1], w[4*rnd+2], w[4*rnd+3]};
    endfunction

    function automatic logic [127:0] model_decrypt(input logic [127:0] k, input logic [127:0] c);
        logic [7:0]   s [0:15];
        logic [7:0]   t [0:15];
        logic [7:0]   coef [0:3];
        logic [7:0]   acc;
        logic [127:0] rkv;
        logic [127:0] o;
        coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
        rkv = model_rk(k, 10);
        for (int j = 0; j < 16; j++) s[j] = c[127 - 8*j -: 8] ^ rkv[127 - 8*j -: 8];
        for (int rnd = 9; rnd >= 0; rnd--) begin
            for (int cc = 0; cc < 4; cc++)
                for (int r = 0; r < 4; r++)
                    t[4*((cc + r) % 4) + r] = isb_t[s[4*cc + r]];
            rkv = model_rk(k, rnd);
            for (int j = 0; j < 16; j++) t[j] = t[j] ^ rkv[127 - 8*j -: 8];
            for (int cc = 0; cc < 4; cc++) begin
                for (int r = 0; r < 4; r++) begin
                    if (rnd > 0) begin
                        acc = 8'h00;
                        for (int j = 0; j < 4; j++) acc = acc ^ gmul(coef[(j - r + 4) % 4], t[4*cc + j]);
                        s[4*cc + r] = acc;
                    end else begin
                        s[4*cc + r] = t[4*cc + r];
                    end
                end
            end
        end
        for (int j = 0; j < 16; j++) o[127 - 8*j -: 8] = s[j];
        return o;
    endfunction

    // Reference timing: accept in idle/done, result 21 edges after the accepting edge
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_done <= 1'b0;
            m_pt   <= '0;
            m_busy <= 1'b0;
            m_cnt  <= 0;
        end else if (!m_busy && start) begin
            m_busy <= 1'b1;
            m_cnt  <= 1;
            m_done <= 1'b0;
            m_next <= model_decrypt(key, cyphertext);
        end else if (m_busy) begin
            m_cnt <= m_cnt + 1;
            if (m_cnt == 21) begin
                m_busy <= 1'b0;
                m_done <= 1'b1;
                m_pt   <= m_next;
            end
        end
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic run_op(input logic [127:0] k, input logic [127:0] c, input bit busy_pulse, output int l);
        @(negedge clk);
        key = k;
        cyphertext = c;
        start = 1'b1;
        l = 0;
        do begin
            @(negedge clk);
            l++;
            start = busy_pulse && (l == 4 || l == 14);
            if (busy_pulse) begin
                key = ~k;
                cyphertext = c ^ {4{32'hdeadbeef}};
            end
        end while (!done && l < 60);
    endtask

    initial begin
        aff_c = 8'h63;
        for (int a = 0; a < 256; a++) begin
            inv_b = 8'h00;
            for (int x = 1; x < 256; x++) if (gmul(8'(a), 8'(x)) == 8'h01) inv_b = 8'(x);
            for (int i = 0; i < 8; i++)
                sv[i] = inv_b[i] ^ inv_b[(i+4)%8] ^ inv_b[(i+5)%8] ^ inv_b[(i+6)%8] ^ inv_b[(i+7)%8] ^ aff_c[i];
            sb_t[a] = sv;
            isb_t[sv] = 8'(a);
        end

        check("pin_sbox_00", 128'(sb_t[8'h00]), 128'h63);
        check("pin_sbox_53", 128'(sb_t[8'h53]), 128'hed);
        check("pin_isbox_00", 128'(isb_t[8'h00]), 128'h52);
        check("pin_model_rk10", model_rk(B_KEY, 10), B_RK10);
        check("pin_model_c1", model_decrypt(C1_KEY, C1_CT), C1_PT);
        check("pin_model_b", model_decrypt(B_KEY, B_CT), B_PT);

        fork
            forever begin
                @(negedge clk);
                check("cyc_done", 128'(done), 128'(m_done));
                check("cyc_pt", plaintext, m_pt);
            end
        join_none

        repeat (3) @(negedge clk);
        check("rst_done", 128'(done), 128'h0);
        check("rst_pt", plaintext, 128'h0);
        check("rst_rcnt", 128'(dut.rcnt), 128'h0);
        reset = 1'b0;

        idle_ok = 1'b1;
        repeat (50) begin
            @(negedge clk);
            if (done !== 1'b0 || plaintext !== 128'h0) idle_ok = 1'b0;
        end
        check("idle_stable", 128'(idle_ok), 128'h1);

        run_op(C1_KEY, C1_CT, 1'b0, lat);
        check("c1_latency", 128'(lat), 128'd22);
        check("c1_pt", plaintext, C1_PT);

        run_op(B_KEY, B_CT, 1'b1, lat);
        check("busy_latency", 128'(lat), 128'd22);
        check("busy_pt", plaintext, B_PT);
        check("busy_rk10", dut.rk[10], B_RK10);
        repeat (25) @(negedge clk);
        check("busy_no_second_done", 128'(done), 128'h1);
        check("busy_no_second_pt", plaintext, B_PT);

        @(negedge clk);
        key = C1_KEY;
        cyphertext = C1_CT;
        start = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!done && n < 60);
        check("b2b_first_latency", 128'(n), 128'd22);
        check("b2b_first_pt", plaintext, C1_PT);
        key = B_KEY;
        cyphertext = B_CT;
        low = 0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (!done) begin
                low++;
                if (plaintext !== C1_PT) check("b2b_hold_pt", plaintext, C1_PT);
            end
        end while (!(done && low > 0) && n < 60);
        start = 1'b0;
        check("b2b_low_cycles", 128'(low), 128'd21);
        check("b2b_second_pt", plaintext, B_PT);

        @(negedge clk);
        key = C1_KEY;
        cyphertext = B_CT;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (12) @(negedge clk);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("rst_async_done", 128'(done), 128'h0);
        check("rst_async_pt", plaintext, 128'h0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        run_op(C1_KEY, C1_CT, 1'b0, lat);
        check("after_rst_latency", 128'(lat), 128'd22);
        check("after_rst_pt", plaintext, C1_PT);
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
